// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter between NUM_REQ byte sources.
// Optional packet lock (grant held until a req_last byte completes) is enabled by defining UART_ARB_PACKET_LOCK_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 8,
   parameter int CNT_W        = 16,
   localparam int ID_W        = $clog2(NUM_REQ),
   localparam int TMO_W       = $clog2(BUSY_TIMEOUT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   tx_en,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   input  logic                   tx_busy,
   input  logic                   tx_done,
   output logic [ID_W-1:0]        grant_id,
   output logic                   arb_busy,
   output logic                   err_timeout,
   output logic [CNT_W-1:0]       tx_count
);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t           state;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  cand;
   logic [ID_W-1:0]  rr_pick;
   logic             rr_found;
   logic [ID_W-1:0]  pick;
   logic             pick_ok;
   logic             finish;
   logic [TMO_W-1:0] tmo_cnt;
   logic [7:0]       src_byte [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
      assign src_byte[i] = req_data[8*i +: 8];
   end

   // Walk the candidates farthest-first so the nearest valid source after ptr is the one left standing.
   always_comb begin
      rr_pick  = ptr;
      rr_found = 1'b0;
      cand     = ptr;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            rr_pick  = cand;
            rr_found = 1'b1;
         end
      end
   end

`ifdef UART_ARB_PACKET_LOCK_EN
   logic lock;
   logic last_q;

   assign pick    = lock ? grant_id : rr_pick;
   assign pick_ok = lock ? req_valid[grant_id] : rr_found;
`else
   logic unused_last;

   assign unused_last = ^req_last;
   assign pick        = rr_pick;
   assign pick_ok     = rr_found;
`endif

   // A same-cycle busy+done in WAIT_BUSY completes the byte just like a done in WAIT_DONE.
   assign finish = ((state == WAIT_BUSY) && tx_busy && tx_done) ||
                   ((state == WAIT_DONE) && tx_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= ID_W'(NUM_REQ - 1);
         tmo_cnt     <= '0;
         grant_id    <= '0;
         req_ready   <= '0;
         tx_en       <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         arb_busy    <= 1'b0;
         err_timeout <= 1'b0;
         tx_count    <= '0;
`ifdef UART_ARB_PACKET_LOCK_EN
         lock        <= 1'b0;
         last_q      <= 1'b0;
`endif
      end else begin
         tx_en       <= enable;
         tx_start    <= 1'b0;
         req_ready   <= '0;
         err_timeout <= 1'b0;
         if (!enable) begin
            state    <= IDLE;
            arb_busy <= 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock     <= 1'b0;
`endif
         end else if (finish) begin
            tx_count <= tx_count + CNT_W'(1);
            state    <= IDLE;
            arb_busy <= 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock     <= ~last_q;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (tx_en && pick_ok) begin
                     grant_id  <= pick;
                     tx_data   <= src_byte[pick];
                     tx_start  <= 1'b1;
                     req_ready <= NUM_REQ'(1) << pick;
                     arb_busy  <= 1'b1;
                     state     <= START;
`ifdef UART_ARB_PACKET_LOCK_EN
                     last_q    <= req_last[pick];
`endif
                  end
               end
               START: begin
                  ptr     <= grant_id;
                  tmo_cnt <= '0;
                  state   <= WAIT_BUSY;
               end
               WAIT_BUSY: begin
                  // The START cycle is the first cycle of the wait, so the pulse lands BUSY_TIMEOUT cycles after tx_start.
                  if (tx_busy) begin
                     state <= WAIT_DONE;
                  end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 2)) begin
                     err_timeout <= 1'b1;
                     arb_busy    <= 1'b0;
                     state       <= IDLE;
`ifdef UART_ARB_PACKET_LOCK_EN
                     lock        <= 1'b0;
`endif
                  end else begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
               end
               WAIT_DONE: begin
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench for uart_tx_arbiter with a transaction-level round-robin model.
// Building with UART_ARB_PACKET_LOCK_EN also switches the model to packet-locked grants.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int TMO = 8;
   localparam int CW  = 4;

   localparam int K_NORM = 0;
   localparam int K_SAME = 1;
   localparam int K_TMO  = 2;
   localparam int K_DROP = 3;

   typedef struct {
      int            src;
      logic [7:0]    data;
      int            kind;
      int            dly;
      int            frame;
      logic [CW-1:0] cnt;
   } txn_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            tx_en;
   logic            tx_start;
   logic [7:0]      tx_data;
   logic            tx_busy;
   logic            tx_done;
   logic [1:0]      grant_id;
   logic            arb_busy;
   logic            err_timeout;
   logic [CW-1:0]   tx_count;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .tx_en(tx_en), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .tx_done(tx_done),
      .grant_id(grant_id), .arb_busy(arb_busy), .err_timeout(err_timeout), .tx_count(tx_count)
   );

   txn_t       sb_q[$];
   txn_t       resp_q[$];
   int         plan_q[$];
   logic [8:0] src_q   [N][$];
   logic [8:0] stage_q [N][$];

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_active  = 1'b0;
   bit resp_active = 1'b0;
   int fixed_dly   = 0;
   int fixed_frame = 0;

   int            m_ptr      = N - 1;
   logic [CW-1:0] m_cnt      = '0;
   bit            m_lock     = 1'b0;
   int            m_lock_src = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Turns the staged source queues into the expected grant sequence, then releases them to the sources.
   task automatic applyStimulus();
      logic [8:0] pend [N][$];
      logic [8:0] b;
      txn_t       e;
      int         total;
      int         s;
      int         r;
      total = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = stage_q[i];
         total += pend[i].size();
      end
      for (int t = 0; t < total; t++) begin
         if (m_lock && pend[m_lock_src].size() > 0) begin
            s = m_lock_src;
         end else begin
            m_lock = 1'b0;
            s = -1;
            for (int k = 1; k <= N; k++)
               if (s < 0 && pend[(m_ptr + k) % N].size() > 0) s = (m_ptr + k) % N;
         end
         b = pend[s].pop_front();
         if (plan_q.size() > 0) begin
            e.kind = plan_q.pop_front();
         end else begin
            r = $urandom_range(0, 9);
            e.kind = (r < 6) ? K_NORM : (r < 8) ? K_SAME : K_TMO;
         end
         e.src   = s;
         e.data  = b[7:0];
         e.dly   = (fixed_dly > 0) ? fixed_dly : $urandom_range(1, 4);
         e.frame = (fixed_frame > 0) ? fixed_frame : $urandom_range(1, 6);
         m_ptr = s;
         if (e.kind == K_NORM || e.kind == K_SAME) begin
            m_cnt = m_cnt + 1'b1;
`ifdef UART_ARB_PACKET_LOCK_EN
            m_lock     = ~b[8];
            m_lock_src = s;
`else
            m_lock = 1'b0;
`endif
         end else begin
            m_lock = 1'b0;
         end
         e.cnt = m_cnt;
         sb_q.push_back(e);
         resp_q.push_back(e);
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         src_q[i] = stage_q[i];
         stage_q[i].delete();
      end
   endtask

   task automatic waitDrain(input int budget);
      int c;
      bit done;
      c = 0;
      done = 1'b0;
      while (!done && c < budget) begin
         @(negedge clk);
         c++;
         done = (sb_q.size() == 0) && !mon_active && !resp_active;
         for (int i = 0; i < N; i++) if (src_q[i].size() > 0) done = 1'b0;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL drain_timeout: %0d expected grants still pending after %0d cycles", sb_q.size(), budget);
         sb_q.delete();
         resp_q.delete();
         for (int i = 0; i < N; i++) src_q[i].delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic doReset();
      enable = 1'b0;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_ptr  = N - 1;
      m_cnt  = '0;
      m_lock = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Sources: hold the head byte until its accept pulse, then present the next one.
   initial begin
      logic [8:0] h;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] === 1'b1 && src_q[i].size() > 0) h = src_q[i].pop_front();
            if (src_q[i].size() > 0) begin
               h = src_q[i][0];
               req_valid[i]         = 1'b1;
               req_data[8*i +: 8]   = h[7:0];
               req_last[i]          = h[8];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Transmitter model: busy/done timing per transaction, or a mid-frame enable drop.
   initial begin
      txn_t r;
      tx_busy = 1'b0;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1 && resp_q.size() > 0) begin
            resp_active = 1'b1;
            r = resp_q.pop_front();
            case (r.kind)
               K_NORM: begin
                  repeat (r.dly) @(negedge clk);
                  tx_busy = 1'b1;
                  repeat (r.frame) @(negedge clk);
                  tx_busy = 1'b0;
                  tx_done = 1'b1;
                  @(negedge clk);
                  tx_done = 1'b0;
               end
               K_SAME: begin
                  repeat (r.dly) @(negedge clk);
                  tx_busy = 1'b1;
                  tx_done = 1'b1;
                  @(negedge clk);
                  tx_busy = 1'b0;
                  tx_done = 1'b0;
               end
               K_DROP: begin
                  @(negedge clk);
                  tx_busy = 1'b1;
                  repeat (3) @(negedge clk);
                  enable = 1'b0;
                  repeat (2) @(negedge clk);
                  tx_busy = 1'b0;
                  enable  = 1'b1;
               end
               default: begin
               end
            endcase
            resp_active = 1'b0;
         end
      end
   end

   // Monitor: every tx_start pops the next expected grant and follows it to completion.
   initial begin
      txn_t e;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected_tx_start: grant_id=%0d tx_data=0x%0h with no grant expected", grant_id, tx_data);
            end else begin
               mon_active = 1'b1;
               e = sb_q.pop_front();
               checkOutput("grant_id", 32'(grant_id), 32'(e.src));
               checkOutput("tx_data", 32'(tx_data), 32'(e.data));
               checkOutput("req_ready", 32'(req_ready), 32'(1) << e.src);
               checkOutput("arb_busy_start", 32'(arb_busy), 32'(1));
               case (e.kind)
                  K_NORM, K_SAME: begin
                     if (e.kind == K_NORM) repeat (e.dly + e.frame + 1) @(negedge clk);
                     else                  repeat (e.dly + 1) @(negedge clk);
                     checkOutput("tx_count_done", 32'(tx_count), 32'(e.cnt));
                     checkOutput("arb_busy_after_done", 32'(arb_busy), 32'(0));
                  end
                  K_TMO: begin
                     repeat (TMO - 1) @(negedge clk);
                     checkOutput("err_timeout_early", 32'(err_timeout), 32'(0));
                     @(negedge clk);
                     checkOutput("err_timeout_pulse", 32'(err_timeout), 32'(1));
                     checkOutput("tx_count_timeout", 32'(tx_count), 32'(e.cnt));
                     checkOutput("arb_busy_timeout", 32'(arb_busy), 32'(0));
                  end
                  default: begin
                     repeat (5) @(negedge clk);
                     checkOutput("tx_en_drop", 32'(tx_en), 32'(0));
                     checkOutput("arb_busy_drop", 32'(arb_busy), 32'(0));
                     checkOutput("tx_count_drop", 32'(tx_count), 32'(e.cnt));
                  end
               endcase
               mon_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic       lb;
      logic [7:0] db;
      int         n;
      rst    = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'(0));
      checkOutput("rst_tx_en", 32'(tx_en), 32'(0));
      checkOutput("rst_tx_start", 32'(tx_start), 32'(0));
      checkOutput("rst_tx_data", 32'(tx_data), 32'(0));
      checkOutput("rst_grant_id", 32'(grant_id), 32'(0));
      checkOutput("rst_arb_busy", 32'(arb_busy), 32'(0));
      checkOutput("rst_err_timeout", 32'(err_timeout), 32'(0));
      checkOutput("rst_tx_count", 32'(tx_count), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      checkOutput("tx_en_follow", 32'(tx_en), 32'(1));
      @(negedge clk);

      $display("[TB] single source 2, byte 0x5A");
      stage_q[2].push_back({1'b1, 8'h5A});
      fixed_dly   = 1;
      fixed_frame = 20;
      plan_q.push_back(K_NORM);
      applyStimulus();
      waitDrain(200);
      fixed_dly   = 0;
      fixed_frame = 0;

      $display("[TB] all four sources, two bytes each");
      doReset();
      for (int i = 0; i < N; i++) begin
         db = 8'h10 + 8'(17 * i);
         stage_q[i].push_back({1'b1, db});
         stage_q[i].push_back({1'b1, db});
      end
      for (int j = 0; j < 8; j++) plan_q.push_back(K_NORM);
      applyStimulus();
      waitDrain(600);
      checkOutput("tx_count_after_8", 32'(tx_count), 32'(8));

      $display("[TB] transmitter never goes busy on the first grant");
      for (int i = 0; i < N; i++) stage_q[i].push_back({1'b1, 8'(8'hA0 + i)});
      plan_q.push_back(K_TMO);
      for (int j = 0; j < 3; j++) plan_q.push_back(K_NORM);
      applyStimulus();
      waitDrain(400);

      $display("[TB] enable dropped inside WAIT_DONE");
      stage_q[0].push_back({1'b1, 8'hC0});
      stage_q[1].push_back({1'b1, 8'hC1});
      plan_q.push_back(K_DROP);
      plan_q.push_back(K_NORM);
      applyStimulus();
      waitDrain(300);

      $display("[TB] randomized batches");
      for (int bt = 0; bt < 8; bt++) begin
         for (int i = 0; i < N; i++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
               lb = (j == n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
               db = 8'($urandom);
               stage_q[i].push_back({lb, db});
            end
         end
         applyStimulus();
         waitDrain(1000);
      end

      $display("[TB] source 1 packet of three bytes against source 2");
      stage_q[1].push_back({1'b0, 8'h61});
      stage_q[1].push_back({1'b0, 8'h62});
      stage_q[1].push_back({1'b1, 8'h63});
      stage_q[2].push_back({1'b1, 8'h71});
      for (int j = 0; j < 4; j++) plan_q.push_back(K_NORM);
      applyStimulus();
      waitDrain(400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
